// File: rtl/atm_multi_account_ctrl.sv
// atm_multi_account_ctrl
// Multi-account ATM session controller. It authenticates a card session
// against a per-account PIN, locks an account after repeated wrong PINs, and
// runs one transaction per request handshake: balance, withdraw, deposit,
// transfer, PIN change or finish.
//
// Optional feature: define ATM_DAILY_LIMIT_EN to keep a per-session withdrawn
// total and reject withdrawals that would exceed DAILY_LIMIT (status LIMIT).
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   Card_in        card present level
//   acct_idx       card account, latched when a session starts
//   pin_valid      PIN entry strobe (used in PIN_WAIT only)
//   password       entered PIN
//   op_valid       transaction request strobe (used in MENU only)
//   opcode         001 bal, 010 wd, 011 dep, 100 xfer, 101 pin, 110 finish
//   amount         withdraw/deposit/transfer amount
//   dest_idx       transfer destination account
//   new_pin        replacement PIN
//   busy           high in EXEC and RESP
//   authenticated  high in MENU, EXEC and RESP
//   done           one-cycle completion pulse
//   status         result code, valid with done
//   balance_out    session balance after the operation, valid with done
//   eject          one-cycle pulse on session end
//   timeout        one-cycle pulse with eject when the idle timer expired
module atm_multi_account_ctrl #(
    parameter int unsigned      NUM_ACCOUNTS = 4,
    parameter int unsigned      IDX_W        = 2,
    parameter int unsigned      PIN_W        = 16,
    parameter int unsigned      AMT_W        = 19,
    parameter int unsigned      INIT_BALANCE = 1000,
    parameter logic [PIN_W-1:0] INIT_PIN     = PIN_W'(16'h1234),
    parameter int unsigned      MAX_TRIES    = 3,
    parameter int unsigned      TIMEOUT_CYC  = 64,
    parameter int unsigned      DAILY_LIMIT  = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Card_in,
    input  logic [IDX_W-1:0] acct_idx,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] password,
    input  logic             op_valid,
    input  logic [2:0]       opcode,
    input  logic [AMT_W-1:0] amount,
    input  logic [IDX_W-1:0] dest_idx,
    input  logic [PIN_W-1:0] new_pin,
    output logic             busy,
    output logic             authenticated,
    output logic             done,
    output logic [2:0]       status,
    output logic [AMT_W-1:0] balance_out,
    output logic             eject,
    output logic             timeout
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] OP_BAL  = 3'b001;
    localparam logic [2:0] OP_WD   = 3'b010;
    localparam logic [2:0] OP_DEP  = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b100;
    localparam logic [2:0] OP_PIN  = 3'b101;
    localparam logic [2:0] OP_FIN  = 3'b110;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NSF      = 3'd1;
    localparam logic [2:0] ST_BAD_ACCT = 3'd2;
    localparam logic [2:0] ST_OVERFLOW = 3'd3;
    localparam logic [2:0] ST_ILLEGAL  = 3'd4;
    localparam logic [2:0] ST_BAD_PIN  = 3'd5;
    localparam logic [2:0] ST_LOCKED   = 3'd6;
    localparam logic [2:0] ST_LIMIT    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_PIN_WAIT, S_MENU, S_EXEC, S_RESP, S_EJECT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, r_dest;
    logic [2:0]         r_op;
    logic [AMT_W-1:0]   r_amt;
    logic [PIN_W-1:0]   r_newpin;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_armed;
    logic               r_done, r_eject, r_timeout, r_busy, r_auth;
    logic [2:0]         r_status;
    logic [AMT_W-1:0]   r_bal_out;

    logic [AMT_W-1:0]   r_bal   [NUM_ACCOUNTS];
    logic [PIN_W-1:0]   r_pin   [NUM_ACCOUNTS];
    logic               r_lock  [NUM_ACCOUNTS];
    logic [TRY_W-1:0]   r_tries [NUM_ACCOUNTS];

    logic               w_in_idx_ok, w_dst_in_rng, w_dest_ok, w_nsf, w_limit_hit;
    logic [AMT_W-1:0]   w_bal_own, w_bal_dst, w_diff;
    logic [AMT_W:0]     w_sum_own, w_sum_dst;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic               w_tmo_hit, w_tmo_run;
    logic               w_done_nxt, w_timeout_nxt, w_latch_idx, w_latch_op, w_tmo_clr;
    logic [2:0]         w_status_nxt;
    logic [AMT_W-1:0]   w_bal_out_nxt, w_bal_src_val, w_bal_dst_val;
    logic               w_bal_src_we, w_bal_dst_we, w_pin_we, w_lock_set, w_try_inc, w_try_clr;

    // Range checks only exist when the index can encode unused accounts
    if ((1 << IDX_W) > NUM_ACCOUNTS) begin : g_idx_chk
        assign w_in_idx_ok  = 32'(acct_idx) < NUM_ACCOUNTS;
        assign w_dst_in_rng = 32'(r_dest) < NUM_ACCOUNTS;
    end else begin : g_idx_full
        assign w_in_idx_ok  = 1'b1;
        assign w_dst_in_rng = 1'b1;
    end

    assign w_bal_own   = r_bal[r_idx];
    assign w_bal_dst   = w_dst_in_rng ? r_bal[r_dest] : '0;
    assign w_diff      = w_bal_own - r_amt;
    assign w_sum_own   = {1'b0, w_bal_own} + {1'b0, r_amt};
    assign w_sum_dst   = {1'b0, w_bal_dst} + {1'b0, r_amt};
    assign w_nsf       = r_amt > w_bal_own;
    assign w_dest_ok   = w_dst_in_rng && (r_dest != r_idx) && !r_lock[r_dest];
    assign w_tries_nxt = r_tries[r_idx] + TRY_W'(1);
    assign w_tmo_run   = (r_state == S_PIN_WAIT) || (r_state == S_MENU);
    assign w_tmo_hit   = r_tmo == TMO_W'(TIMEOUT_CYC - 1);

`ifdef ATM_DAILY_LIMIT_EN
    // Session withdrawn total; cleared when the session ejects
    logic [AMT_W:0]   r_wd_total;
    logic [AMT_W+1:0] w_wd_sum;
    assign w_wd_sum    = {1'b0, r_wd_total} + {2'b00, r_amt};
    assign w_limit_hit = w_wd_sum > (AMT_W+2)'(DAILY_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_total <= '0;
        end else if (r_state == S_EJECT) begin
            r_wd_total <= '0;
        end else if (r_state == S_EXEC && r_op == OP_WD && w_bal_src_we) begin
            r_wd_total <= r_wd_total + (AMT_W+1)'(r_amt);
        end
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, result codes and account-store write controls
    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = 1'b0;
        w_status_nxt  = ST_OK;
        w_bal_out_nxt = '0;
        w_timeout_nxt = 1'b0;
        w_latch_idx   = 1'b0;
        w_latch_op    = 1'b0;
        w_tmo_clr     = 1'b0;
        w_bal_src_we  = 1'b0;
        w_bal_src_val = w_bal_own;
        w_bal_dst_we  = 1'b0;
        w_bal_dst_val = w_bal_dst;
        w_pin_we      = 1'b0;
        w_lock_set    = 1'b0;
        w_try_inc     = 1'b0;
        w_try_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Card_in && r_armed) begin
                    w_latch_idx = 1'b1;
                    if (!w_in_idx_ok) begin
                        w_done_nxt   = 1'b1;
                        w_status_nxt = ST_BAD_ACCT;
                        w_state_nxt  = S_EJECT;
                    end else if (r_lock[acct_idx]) begin
                        w_done_nxt   = 1'b1;
                        w_status_nxt = ST_LOCKED;
                        w_state_nxt  = S_EJECT;
                    end else begin
                        w_state_nxt  = S_PIN_WAIT;
                    end
                end
            end
            S_PIN_WAIT: begin
                if (!Card_in) begin
                    w_state_nxt = S_EJECT;
                end else if (pin_valid) begin
                    w_tmo_clr  = 1'b1;
                    w_done_nxt = 1'b1;
                    if (password == r_pin[r_idx]) begin
                        w_try_clr   = 1'b1;
                        w_state_nxt = S_MENU;
                    end else if (32'(w_tries_nxt) >= MAX_TRIES) begin
                        w_try_inc    = 1'b1;
                        w_lock_set   = 1'b1;
                        w_status_nxt = ST_LOCKED;
                        w_state_nxt  = S_EJECT;
                    end else begin
                        w_try_inc    = 1'b1;
                        w_status_nxt = ST_BAD_PIN;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_EJECT;
                end
            end
            S_MENU: begin
                // Card removal beats a simultaneous request
                if (!Card_in) begin
                    w_state_nxt = S_EJECT;
                end else if (op_valid) begin
                    w_latch_op  = 1'b1;
                    w_tmo_clr   = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (w_tmo_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_EJECT;
                end
            end
            S_EXEC: begin
                // Commits even if the card was pulled; the abort is taken after RESP
                w_state_nxt   = S_RESP;
                w_done_nxt    = 1'b1;
                w_bal_out_nxt = w_bal_own;
                case (r_op)
                    OP_BAL, OP_FIN: w_status_nxt = ST_OK;
                    OP_WD: begin
                        if (w_limit_hit)  w_status_nxt = ST_LIMIT;
                        else if (w_nsf)   w_status_nxt = ST_NSF;
                        else begin
                            w_bal_src_we  = 1'b1;
                            w_bal_src_val = w_diff;
                            w_bal_out_nxt = w_diff;
                        end
                    end
                    OP_DEP: begin
                        if (w_sum_own[AMT_W]) w_status_nxt = ST_OVERFLOW;
                        else begin
                            w_bal_src_we  = 1'b1;
                            w_bal_src_val = w_sum_own[AMT_W-1:0];
                            w_bal_out_nxt = w_sum_own[AMT_W-1:0];
                        end
                    end
                    OP_XFER: begin
                        if (!w_dest_ok)             w_status_nxt = ST_BAD_ACCT;
                        else if (w_nsf)             w_status_nxt = ST_NSF;
                        else if (w_sum_dst[AMT_W])  w_status_nxt = ST_OVERFLOW;
                        else begin
                            w_bal_src_we  = 1'b1;
                            w_bal_src_val = w_diff;
                            w_bal_dst_we  = 1'b1;
                            w_bal_dst_val = w_sum_dst[AMT_W-1:0];
                            w_bal_out_nxt = w_diff;
                        end
                    end
                    OP_PIN:  w_pin_we     = 1'b1;
                    default: w_status_nxt = ST_ILLEGAL;
                endcase
            end
            S_RESP: begin
                if (r_op == OP_FIN || !Card_in) w_state_nxt = S_EJECT;
                else                            w_state_nxt = S_MENU;
            end
            S_EJECT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Session latches, idle timer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_dest    <= '0;
            r_op      <= '0;
            r_amt     <= '0;
            r_newpin  <= '0;
            r_tmo     <= '0;
            r_armed   <= 1'b1;
            r_done    <= 1'b0;
            r_status  <= '0;
            r_bal_out <= '0;
            r_eject   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_auth    <= 1'b0;
        end else begin
            if (w_latch_idx) r_idx <= acct_idx;
            if (w_latch_op) begin
                r_op     <= opcode;
                r_amt    <= amount;
                r_dest   <= dest_idx;
                r_newpin <= new_pin;
            end
            if (w_tmo_clr || !w_tmo_run) r_tmo <= '0;
            else                         r_tmo <= r_tmo + TMO_W'(1);
            // A new session needs the card to be seen absent first
            if (w_latch_idx)   r_armed <= 1'b0;
            else if (!Card_in) r_armed <= 1'b1;
            r_done    <= w_done_nxt;
            r_status  <= w_status_nxt;
            r_bal_out <= w_bal_out_nxt;
            r_eject   <= (w_state_nxt == S_EJECT);
            r_timeout <= w_timeout_nxt;
            r_busy    <= (w_state_nxt == S_EXEC) || (w_state_nxt == S_RESP);
            r_auth    <= (w_state_nxt == S_MENU) || (w_state_nxt == S_EXEC) ||
                         (w_state_nxt == S_RESP);
        end
    end

    // Persistent account store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
                r_bal[i]   <= AMT_W'(INIT_BALANCE);
                r_pin[i]   <= INIT_PIN;
                r_lock[i]  <= 1'b0;
                r_tries[i] <= '0;
            end
        end else begin
            if (w_bal_src_we) r_bal[r_idx]  <= w_bal_src_val;
            if (w_bal_dst_we) r_bal[r_dest] <= w_bal_dst_val;
            if (w_pin_we)     r_pin[r_idx]  <= r_newpin;
            if (w_lock_set)   r_lock[r_idx] <= 1'b1;
            if (w_try_clr)      r_tries[r_idx] <= '0;
            else if (w_try_inc) r_tries[r_idx] <= w_tries_nxt;
        end
    end

    assign busy          = r_busy;
    assign authenticated = r_auth;
    assign done          = r_done;
    assign status        = r_status;
    assign balance_out   = r_bal_out;
    assign eject         = r_eject;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Directed bench for atm_multi_account_ctrl with a result scoreboard.
module tb_atm_multi_account_ctrl;

    localparam int unsigned AMT_W = 19;

    localparam logic [2:0] OP_BAL = 3'b001, OP_WD = 3'b010, OP_DEP = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b100, OP_PIN = 3'b101, OP_FIN = 3'b110;
    localparam logic [2:0] ST_OK = 3'd0, ST_NSF = 3'd1, ST_BAD = 3'd2, ST_OVF = 3'd3;
    localparam logic [2:0] ST_ILL = 3'd4, ST_BADPIN = 3'd5, ST_LOCK = 3'd6, ST_LIMIT = 3'd7;

`ifdef ATM_DAILY_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             Card_in = 1'b0;
    logic [1:0]       acct_idx = '0;
    logic             pin_valid = 1'b0;
    logic [15:0]      password = '0;
    logic             op_valid = 1'b0;
    logic [2:0]       opcode = '0;
    logic [AMT_W-1:0] amount = '0;
    logic [1:0]       dest_idx = '0;
    logic [15:0]      new_pin = '0;
    logic             busy, authenticated, done, eject, timeout;
    logic [2:0]       status;
    logic [AMT_W-1:0] balance_out;

    typedef struct packed {
        logic [2:0]       st;
        logic [AMT_W-1:0] bal;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    atm_multi_account_ctrl dut (
        .clk(clk), .reset(reset), .Card_in(Card_in), .acct_idx(acct_idx),
        .pin_valid(pin_valid), .password(password), .op_valid(op_valid),
        .opcode(opcode), .amount(amount), .dest_idx(dest_idx), .new_pin(new_pin),
        .busy(busy), .authenticated(authenticated), .done(done), .status(status),
        .balance_out(balance_out), .eject(eject), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every done pulse consumes the oldest expected result
    always @(negedge clk) begin
        if (reset && done === 1'b1) begin
            exp_t e;
            chk("sb_pending", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("status", 32'(status), 32'(e.st));
                chk("balance_out", 32'(balance_out), 32'(e.bal));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] idx);
        Card_in = 1'b0;
        cyc();
        Card_in  = 1'b1;
        acct_idx = idx;
        cyc();
    endtask

    task automatic do_pin(input logic [15:0] pw, input logic [2:0] exp_st);
        sb_q.push_back({exp_st, AMT_W'(0)});
        password  = pw;
        pin_valid = 1'b1;
        cyc();
        pin_valid = 1'b0;
        @(negedge clk);
        chk("pin_done", 32'(done), 1);
    endtask

    task automatic do_op(input logic [2:0] op, input int unsigned amt, input logic [1:0] dst,
                         input logic [15:0] np, input logic [2:0] exp_st,
                         input int unsigned exp_bal, input bit pull);
        sb_q.push_back({exp_st, AMT_W'(exp_bal)});
        opcode   = op;
        amount   = AMT_W'(amt);
        dest_idx = dst;
        new_pin  = np;
        op_valid = 1'b1;
        cyc();
        op_valid = 1'b0;
        if (pull) Card_in = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 1);
        chk("exec_no_done", 32'(done), 0);
        @(negedge clk);
        chk("resp_done", 32'(done), 1);
        cyc();
    endtask

    task automatic chk_eject(input string tag);
        chk(tag, 32'(eject), 1);
        chk({tag, "_no_timeout"}, 32'(timeout), 0);
    endtask

    initial begin
        int n;
        // Reset values
        @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_auth", 32'(authenticated), 0);
        chk("rst_eject", 32'(eject), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_balance", 32'(balance_out), 0);
        cyc();
        reset = 1'b1;

        // Account 0: basic operations and boundaries
        insert(2'd0);
        chk("pinwait_auth", 32'(authenticated), 0);
        do_pin(16'h1234, ST_OK);
        chk("menu_auth", 32'(authenticated), 1);
        do_op(OP_BAL, 0, 2'd0, 16'h0, ST_OK, 1000, 1'b0);
        do_op(OP_WD, 300, 2'd0, 16'h0, ST_OK, 700, 1'b0);
        do_op(OP_DEP, 50, 2'd0, 16'h0, ST_OK, 750, 1'b0);
        do_op(OP_WD, 800, 2'd0, 16'h0, LIM ? ST_LIMIT : ST_NSF, 750, 1'b0);
        do_op(OP_WD, 0, 2'd0, 16'h0, ST_OK, 750, 1'b0);
        do_op(OP_DEP, 523538, 2'd0, 16'h0, ST_OVF, 750, 1'b0);
        do_op(3'b000, 5, 2'd0, 16'h0, ST_ILL, 750, 1'b0);
        do_op(3'b111, 5, 2'd0, 16'h0, ST_ILL, 750, 1'b0);
        do_op(OP_FIN, 0, 2'd0, 16'h0, ST_OK, 750, 1'b0);
        chk_eject("fin0_eject");

        // Account 1: transfers
        insert(2'd1);
        do_pin(16'h1234, ST_OK);
        do_op(OP_XFER, 200, 2'd2, 16'h0, ST_OK, 800, 1'b0);
        do_op(OP_XFER, 50, 2'd1, 16'h0, ST_BAD, 800, 1'b0);
        do_op(OP_XFER, 900, 2'd3, 16'h0, ST_NSF, 800, 1'b0);
        do_op(OP_FIN, 0, 2'd0, 16'h0, ST_OK, 800, 1'b0);
        chk_eject("fin1_eject");

        // Account 2: credited balance, PIN change, abort during EXEC
        insert(2'd2);
        do_pin(16'h1234, ST_OK);
        do_op(OP_BAL, 0, 2'd0, 16'h0, ST_OK, 1200, 1'b0);
        do_op(OP_PIN, 0, 2'd0, 16'hBEEF, ST_OK, 1200, 1'b0);
        do_op(OP_FIN, 0, 2'd0, 16'h0, ST_OK, 1200, 1'b0);
        chk_eject("fin2_eject");
        insert(2'd2);
        do_pin(16'h1234, ST_BADPIN);
        do_pin(16'hBEEF, ST_OK);
        do_op(OP_DEP, 10, 2'd0, 16'h0, ST_OK, 1210, 1'b1);
        chk_eject("pull_eject");

        // Account 3: lockout, then rejection even with the right PIN
        insert(2'd3);
        do_pin(16'h0000, ST_BADPIN);
        do_pin(16'h0001, ST_BADPIN);
        do_pin(16'h0002, ST_LOCK);
        chk("lock_eject", 32'(eject), 1);
        Card_in = 1'b0;
        cyc();
        sb_q.push_back({ST_LOCK, AMT_W'(0)});
        Card_in   = 1'b1;
        acct_idx  = 2'd3;
        password  = 16'h1234;
        pin_valid = 1'b1;
        cyc();
        @(negedge clk);
        chk("rej_done", 32'(done), 1);
        chk("rej_eject", 32'(eject), 1);
        chk("rej_auth", 32'(authenticated), 0);
        repeat (3) cyc();
        pin_valid = 1'b0;
        chk("rej_still_out", 32'(authenticated), 0);

        // Idle timeout in MENU
        insert(2'd0);
        do_pin(16'h1234, ST_OK);
        n = 0;
        while (eject !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 64);
        chk("tmo_flag", 32'(timeout), 1);
        @(negedge clk);
        chk("tmo_pulse_end", 32'(timeout), 0);

        // Session withdraw limit on account 0 (750)
        insert(2'd0);
        do_pin(16'h1234, ST_OK);
        do_op(OP_WD, 400, 2'd0, 16'h0, ST_OK, 350, 1'b0);
        do_op(OP_WD, 200, 2'd0, 16'h0, LIM ? ST_LIMIT : ST_OK, LIM ? 350 : 150, 1'b0);
        do_op(OP_FIN, 0, 2'd0, 16'h0, ST_OK, LIM ? 350 : 150, 1'b0);
        chk_eject("fin_lim_eject");

        Card_in = 1'b0;
        repeat (3) cyc();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
